// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle direction encoding, playfield geometry and
// the default keyboard bytes used by both player paddles.
package pong_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int SCREEN_H = 480;
  localparam int TOP      = 15;
  localparam int BOTTOM   = 465;

  localparam logic [7:0] KEY_UP   = 8'd119;  // 'w'
  localparam logic [7:0] KEY_DOWN = 8'd115;  // 's'
  localparam logic [7:0] KEY_STOP = 8'd32;   // space

endpackage

// File: rtl/paddle_ctrl_if.sv
// Game-side bundle of one paddle: frame/key/CPU-mode inputs and the paddle
// state consumed by the renderer and collision logic.
interface paddle_ctrl_if #(
  parameter int Y_W = 10
);
  // i_key_valid is a one-cycle strobe qualifying i_key_byte; there is no ready,
  // the paddle accepts every strobe in the cycle it is presented.
  logic           i_frame_tick;
  logic           i_key_valid;
  logic [7:0]     i_key_byte;
  logic           i_cpu_mode;
  logic [Y_W-1:0] i_ball_y;
  logic [Y_W-1:0] o_y_pos;
  logic [1:0]     o_dir;
  logic [3:0]     o_speed;
  logic           o_at_top;
  logic           o_at_bottom;

  modport master (
    output i_frame_tick, i_key_valid, i_key_byte, i_cpu_mode, i_ball_y,
    input  o_y_pos, o_dir, o_speed, o_at_top, o_at_bottom
  );

  modport slave (
    input  i_frame_tick, i_key_valid, i_key_byte, i_cpu_mode, i_ball_y,
    output o_y_pos, o_dir, o_speed, o_at_top, o_at_bottom
  );
endinterface

// File: rtl/paddle_speed_ramp.sv
// Step-size register for one paddle: ramps by one every ACCEL_TICKS moving
// ticks up to SPEED_MAX, drops back to SPEED_MIN on clear, or pins CPU_SPEED.
module paddle_speed_ramp #(
  parameter int SPEED_MIN   = 2,
  parameter int SPEED_MAX   = 8,
  parameter int ACCEL_TICKS = 4,
  parameter int CPU_SPEED   = 3
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       tick,
  input  logic       moved,
  input  logic       clear,
  input  logic       load_cpu,
  output logic [3:0] speed
);

  localparam int ACC_W = $clog2(ACCEL_TICKS) + 1;

  logic [ACC_W-1:0] acc_cnt;

  // clear wins over everything so a key-driven reset lands in the same cycle as a tick
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      speed   <= 4'(SPEED_MIN);
      acc_cnt <= '0;
    end else if (clear) begin
      speed   <= 4'(SPEED_MIN);
      acc_cnt <= '0;
    end else if (load_cpu) begin
      speed   <= 4'(CPU_SPEED);
      acc_cnt <= '0;
    end else if (tick && moved) begin
      if (acc_cnt == ACC_W'(ACCEL_TICKS - 1)) begin
        acc_cnt <= '0;
        if (speed < 4'(SPEED_MAX)) speed <= speed + 4'd1;
      end else begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Frame-paced Pong paddle: keyboard direction FSM (IDLE/UP/DOWN) or CPU ball
// tracking, clamped to the playfield; o_dir is the registered FSM state.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int         Y_W         = 10,
  parameter logic [7:0] UP_KEY      = KEY_UP,
  parameter logic [7:0] DOWN_KEY    = KEY_DOWN,
  parameter logic [7:0] STOP_KEY    = KEY_STOP,
  parameter int         HEIGHT      = 100,
  parameter int         START_Y     = 300,
  parameter int         TOP         = pong_pkg::TOP,
  parameter int         BOTTOM      = pong_pkg::BOTTOM,
  parameter int         SPEED_MIN   = 2,
  parameter int         SPEED_MAX   = 8,
  parameter int         ACCEL_TICKS = 4,
  parameter int         CPU_SPEED   = 3,
  parameter int         DEAD_ZONE   = 8
) (
  input logic          i_CLK,
  input logic          i_RST,
  paddle_ctrl_if.slave bus
);

  if (START_Y < TOP || START_Y + HEIGHT > BOTTOM) begin : g_bad_start
    $error("paddle_ctrl: START_Y outside [TOP, BOTTOM-HEIGHT]");
  end

  localparam logic [Y_W:0]   TOP_X   = (Y_W+1)'(TOP);
  localparam logic [Y_W:0]   BOT_X   = (Y_W+1)'(BOTTOM - HEIGHT);
  localparam logic [Y_W:0]   HALF_X  = (Y_W+1)'(HEIGHT / 2);
  localparam logic [Y_W:0]   DZ_X    = (Y_W+1)'(DEAD_ZONE);
  localparam logic [Y_W:0]   CPU_X   = (Y_W+1)'(CPU_SPEED);
  localparam logic [Y_W-1:0] START_V = Y_W'(START_Y);
  localparam logic [Y_W-1:0] TOP_V   = Y_W'(TOP);
  localparam logic [Y_W-1:0] BOT_V   = Y_W'(BOTTOM - HEIGHT);

  logic [Y_W-1:0] y_q, y_d;
  logic [1:0]     dir_q, dir_d, cpu_dir, mv_dir;
  logic           mode_q, at_top_q, at_bot_q;
  logic [3:0]     speed;
  logic           cpu, mode_chg, key_up, key_down, key_stop;
  logic [Y_W:0]   y_ext, centre, ball_ext, step, y_calc;
  logic           hit, moved, clear, load_cpu;

  always_comb begin
    cpu      = bus.i_cpu_mode;
    mode_chg = cpu ^ mode_q;
    key_up   = bus.i_key_valid && !cpu && (bus.i_key_byte == UP_KEY);
    key_down = bus.i_key_valid && !cpu && (bus.i_key_byte == DOWN_KEY);
    key_stop = bus.i_key_valid && !cpu && (bus.i_key_byte == STOP_KEY);

    // Extra MSB keeps y - step and y + step from wrapping before the clamp.
    y_ext    = {1'b0, y_q};
    centre   = y_ext + HALF_X;
    ball_ext = {1'b0, bus.i_ball_y};
    cpu_dir  = DIR_IDLE;
    if (ball_ext + DZ_X < centre)      cpu_dir = DIR_UP;
    else if (ball_ext > centre + DZ_X) cpu_dir = DIR_DOWN;

    mv_dir = cpu ? cpu_dir : dir_q;
    step   = cpu ? CPU_X : (Y_W+1)'(speed);
    hit    = 1'b0;
    y_calc = y_ext;
    case (mv_dir)
      DIR_UP: begin
        hit    = (y_ext <= TOP_X + step);
        y_calc = hit ? TOP_X : y_ext - step;
      end
      DIR_DOWN: begin
        hit    = (y_ext + step >= BOT_X);
        y_calc = hit ? BOT_X : y_ext + step;
      end
      default: ;
    endcase

    y_d = (bus.i_frame_tick && !mode_chg) ? y_calc[Y_W-1:0] : y_q;

    dir_d = dir_q;
    if (mode_chg)                      dir_d = DIR_IDLE;
    else if (cpu && bus.i_frame_tick)  dir_d = cpu_dir;
    else if (key_up)                   dir_d = DIR_UP;
    else if (key_down)                 dir_d = DIR_DOWN;
    else if (key_stop)                 dir_d = DIR_IDLE;

    // A tick that moves with the old direction still ramps unless clear also fires.
    moved    = !cpu && (dir_q != DIR_IDLE) && !hit;
    load_cpu = cpu && !mode_chg && bus.i_frame_tick;
    clear    = mode_chg ||
               (!cpu && ((key_up && dir_q != DIR_UP) ||
                         (key_down && dir_q != DIR_DOWN) ||
                         key_stop ||
                         (bus.i_frame_tick && dir_q != DIR_IDLE && hit)));
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      y_q      <= START_V;
      dir_q    <= DIR_IDLE;
      mode_q   <= 1'b0;
      at_top_q <= (START_V == TOP_V);
      at_bot_q <= (START_V == BOT_V);
    end else begin
      y_q      <= y_d;
      dir_q    <= dir_d;
      mode_q   <= cpu;
      at_top_q <= (y_d == TOP_V);
      at_bot_q <= (y_d == BOT_V);
    end
  end

  paddle_speed_ramp #(
    .SPEED_MIN  (SPEED_MIN),
    .SPEED_MAX  (SPEED_MAX),
    .ACCEL_TICKS(ACCEL_TICKS),
    .CPU_SPEED  (CPU_SPEED)
  ) u_ramp (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .tick    (bus.i_frame_tick),
    .moved   (moved),
    .clear   (clear),
    .load_cpu(load_cpu),
    .speed   (speed)
  );

  assign bus.o_y_pos     = y_q;
  assign bus.o_dir       = dir_q;
  assign bus.o_speed     = speed;
  assign bus.o_at_top    = at_top_q;
  assign bus.o_at_bottom = at_bot_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: hand vector tables for the motion corner cases plus
// random keyboard/CPU traffic scored against a rule-level paddle model.
module tb_paddle_ctrl;

  localparam int Y_W     = 10;
  localparam int W       = Y_W + 2 + 4 + 2;
  localparam int TOP_Y   = 15;
  localparam int BOT_Y   = 365;
  localparam int HEIGHT  = 100;
  localparam int START   = 300;
  localparam int SPD_MIN = 2;
  localparam int SPD_MAX = 8;
  localparam int ACCEL   = 4;
  localparam int CPU_SPD = 3;
  localparam int DEAD    = 8;

  // clock / reset
  logic i_CLK = 1'b0;
  logic i_RST;
  always #5 i_CLK = ~i_CLK;

  paddle_ctrl_if #(.Y_W(Y_W)) bus ();

  paddle_ctrl #(.Y_W(Y_W)) dut (
    .i_CLK(i_CLK),
    .i_RST(i_RST),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_y, m_dir, m_speed, m_cnt;
  bit m_mode;

  logic [W-1:0] exp_q[$];

  typedef struct {
    bit         tick;
    bit         kv;
    logic [7:0] kb;
    bit         cpu;
    logic [9:0] ball;
    int         y;
    int         dir;
    int         spd;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [W-1:0] pack(input int y, input int dir, input int spd);
    return {Y_W'(y), 2'(dir), 4'(spd), (y == TOP_Y), (y == BOT_Y)};
  endfunction

  function automatic string show(input logic [W-1:0] v);
    return $sformatf("y=%0d dir=%0d spd=%0d top=%0b bot=%0b",
                     v[W-1 -: Y_W], v[7:6], v[5:2], v[1], v[0]);
  endfunction

  function automatic logic [W-1:0] actual();
    return {bus.o_y_pos, bus.o_dir, bus.o_speed, bus.o_at_top, bus.o_at_bottom};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, show(act), show(exp));
    end
  endtask

  task automatic model_step(input bit tick, input bit kv, input int kb,
                            input bit cpu, input int ball);
    bit chg, rs;
    int tgt, nd, c;
    chg    = (cpu != m_mode);
    m_mode = cpu;
    rs     = 1'b0;
    if (chg) begin
      m_dir = 0; m_speed = SPD_MIN; m_cnt = 0;
    end else if (cpu) begin
      if (tick) begin
        c = m_y + HEIGHT / 2;
        if (ball < c - DEAD)      m_dir = 1;
        else if (ball > c + DEAD) m_dir = 2;
        else                      m_dir = 0;
        if (m_dir == 1)      m_y = (m_y - CPU_SPD < TOP_Y) ? TOP_Y : m_y - CPU_SPD;
        else if (m_dir == 2) m_y = (m_y + CPU_SPD > BOT_Y) ? BOT_Y : m_y + CPU_SPD;
        m_speed = CPU_SPD; m_cnt = 0;
      end
    end else begin
      if (tick && m_dir != 0) begin
        tgt = (m_dir == 1) ? m_y - m_speed : m_y + m_speed;
        if (tgt <= TOP_Y)      begin m_y = TOP_Y; rs = 1'b1; end
        else if (tgt >= BOT_Y) begin m_y = BOT_Y; rs = 1'b1; end
        else begin
          m_y = tgt;
          m_cnt++;
          if (m_cnt == ACCEL) begin
            m_cnt = 0;
            if (m_speed < SPD_MAX) m_speed++;
          end
        end
      end
      if (kv) begin
        nd = (kb == 119) ? 1 : (kb == 115) ? 2 : (kb == 32) ? 0 : -1;
        if (nd >= 0) begin
          if (nd == 0 || nd != m_dir) rs = 1'b1;
          m_dir = nd;
        end
      end
      if (rs) begin m_speed = SPD_MIN; m_cnt = 0; end
    end
  endtask

  // scoreboard
  task automatic sb_check();
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb: no expected entry, got %s", show(actual()));
    end else begin
      e = exp_q.pop_front();
      if (actual() !== e) begin
        failures++;
        $display("FAIL sb t=%0t: got %s, expected %s", $time, show(actual()), show(e));
      end
    end
  endtask

  // driver tasks
  task automatic cycle(input bit tick, input bit kv, input logic [7:0] kb,
                       input bit cpu, input logic [9:0] ball);
    bus.i_frame_tick = tick;
    bus.i_key_valid  = kv;
    bus.i_key_byte   = kb;
    bus.i_cpu_mode   = cpu;
    bus.i_ball_y     = ball;
    model_step(tick, kv, int'(kb), cpu, int'(ball));
    exp_q.push_back(pack(m_y, m_dir, m_speed));
    @(posedge i_CLK);
    #1;
    bus.i_frame_tick = 1'b0;
    bus.i_key_valid  = 1'b0;
    sb_check();
  endtask

  task automatic do_reset(input string name);
    bus.i_frame_tick = 1'b0;
    bus.i_key_valid  = 1'b0;
    bus.i_cpu_mode   = 1'b0;
    i_RST = 1'b1;
    #1;
    check(name, actual(), pack(START, 0, SPD_MIN));
    m_y = START; m_dir = 0; m_speed = SPD_MIN; m_cnt = 0; m_mode = 1'b0;
    exp_q.delete();
    @(posedge i_CLK);
    #1;
    i_RST = 1'b0;
  endtask

  task automatic key(input logic [7:0] kb);
    cycle(1'b0, 1'b1, kb, 1'b0, 10'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'd0, 1'b0, 10'd0);
  endtask

  function automatic void add(input bit tick, input bit kv, input logic [7:0] kb,
                              input bit cpu, input logic [9:0] ball,
                              input int y, input int dir, input int spd);
    vec_t v;
    v.tick = tick; v.kv = kv; v.kb = kb; v.cpu = cpu; v.ball = ball;
    v.y = y; v.dir = dir; v.spd = spd;
    tbl.push_back(v);
  endfunction

  task automatic run_vecs(input string name, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cycle(tbl[i].tick, tbl[i].kv, tbl[i].kb, tbl[i].cpu, tbl[i].ball);
      check($sformatf("%s[%0d]", name, i - lo), actual(), pack(tbl[i].y, tbl[i].dir, tbl[i].spd));
    end
  endtask

  initial begin
    int r;
    logic [7:0] kb;
    bit cpu;
    bus.i_key_byte = 8'd0;
    bus.i_ball_y   = 10'd0;

    // ramp 0..8
    add(0, 1, 8'd115, 0, 0, 300, 2, 2);
    add(1, 0, 8'd0, 0, 0, 302, 2, 2);
    add(1, 0, 8'd0, 0, 0, 304, 2, 2);
    add(1, 0, 8'd0, 0, 0, 306, 2, 2);
    add(1, 0, 8'd0, 0, 0, 308, 2, 3);
    add(1, 0, 8'd0, 0, 0, 311, 2, 3);
    add(1, 0, 8'd0, 0, 0, 314, 2, 3);
    add(1, 0, 8'd0, 0, 0, 317, 2, 3);
    add(1, 0, 8'd0, 0, 0, 320, 2, 4);
    // bottom clamp 9..14
    add(0, 1, 8'd115, 0, 0, 360, 2, 2);
    add(1, 0, 8'd0, 0, 0, 362, 2, 2);
    add(1, 0, 8'd0, 0, 0, 364, 2, 2);
    add(1, 0, 8'd0, 0, 0, 365, 2, 2);
    add(1, 0, 8'd0, 0, 0, 365, 2, 2);
    add(1, 0, 8'd0, 0, 0, 365, 2, 2);
    // garbage / stop with tick 15..17
    add(0, 1, 8'd120, 0, 0, 200, 1, 2);
    add(1, 1, 8'd32, 0, 0, 198, 0, 2);
    add(1, 0, 8'd0, 0, 0, 198, 0, 2);
    // CPU tracking 18..22
    add(0, 0, 8'd0, 1, 355, 300, 0, 2);
    add(1, 0, 8'd0, 1, 355, 300, 0, 3);
    add(1, 0, 8'd0, 1, 200, 297, 1, 3);
    add(1, 0, 8'd0, 1, 200, 294, 1, 3);
    add(1, 0, 8'd0, 1, 200, 291, 1, 3);
    // mode switch 23..25
    add(1, 0, 8'd0, 1, 400, 336, 0, 2);
    add(1, 0, 8'd0, 1, 400, 339, 2, 3);
    add(1, 0, 8'd0, 0, 400, 339, 0, 2);

    do_reset("reset_init");
    run_vecs("ramp", 0, 8);
    do_reset("reset_mid_motion");

    for (int g = 0; g < 10; g++) begin key(8'd115); ticks(3); key(8'd32); end
    run_vecs("clamp_bottom", 9, 14);

    do_reset("reset_b");
    for (int g = 0; g < 16; g++) begin key(8'd119); ticks(3); key(8'd32); end
    key(8'd119);
    ticks(2);
    run_vecs("stop", 15, 17);

    do_reset("reset_c");
    run_vecs("cpu", 18, 22);

    do_reset("reset_d");
    key(8'd115);
    ticks(12);
    run_vecs("mode_switch", 23, 25);

    // random traffic against the model
    do_reset("reset_rand");
    cpu = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 199) == 0) cpu = ~cpu;
      r = $urandom_range(0, 3);
      kb = (r == 0) ? 8'd119 : (r == 1) ? 8'd115 : (r == 2) ? 8'd32 : 8'($urandom_range(0, 255));
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, kb, cpu,
            10'($urandom_range(0, 479)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised paddle controller for Pong, one instance per player. It replaces free-running per-clock movement with frame-tick-paced motion. Features: explicit stop key, speed ramp while a direction is held, exact clamping to the playfield, and a CPU mode that tracks the ball. Its output feeds the renderer and the collision logic.

Parameters:
Y_W, 10, width of all vertical coordinates
UP_KEY, 119, key byte for move up ('w')
DOWN_KEY, 115, key byte for move down ('s')
STOP_KEY, 32, key byte for stop (space)
HEIGHT, 100, paddle height in pixels
START_Y, 300, top-edge position after reset
TOP, 15, minimum legal o_y_pos
BOTTOM, 465, maximum legal o_y_pos + HEIGHT
SPEED_MIN, 2, initial pixels per frame tick
SPEED_MAX, 8, speed ceiling
ACCEL_TICKS, 4, consecutive moving ticks per +1 speed step
CPU_SPEED, 3, fixed speed in CPU mode
DEAD_ZONE, 8, CPU tracking half-window in pixels

Ports:
i_CLK  in  1  system clock
i_RST  in  1  asynchronous reset, active-high
i_frame_tick  in  1  one-cycle pulse, once per video frame
i_key_valid  in  1  one-cycle strobe qualifying i_key_byte
i_key_byte  in  8  received ASCII byte
i_cpu_mode  in  1  1 = ball tracking, 0 = keyboard
i_ball_y  in  Y_W  ball centre row
o_y_pos  out  Y_W  paddle top-edge row
o_dir  out  2  00 idle, 01 up, 10 down
o_speed  out  4  current step size
o_at_top  out  1  o_y_pos == TOP
o_at_bottom  out  1  o_y_pos == BOTTOM-HEIGHT

Behaviour:
- Reset is one clock, asynchronous and active-high. During reset: o_y_pos=START_Y, o_dir=IDLE, o_speed=SPEED_MIN, accel counter=0, flags decoded from START_Y.
- FSM states: IDLE, UP, DOWN; o_dir is the registered state.
- Keyboard mode, on i_key_valid:
  - UP_KEY -> UP; DOWN_KEY -> DOWN; STOP_KEY -> IDLE.
  - Other bytes are ignored.
  - Input changes only direction, never position.
- Position update happens only on i_frame_tick:
  - UP: y_next = max(TOP, y - speed).
  - DOWN: y_next = min(BOTTOM-HEIGHT, y + speed).
  - Compute in Y_W+1 bits so subtraction cannot wrap.
- Ramp:
  - Each tick that actually moves the paddle increments the accel counter.
  - When the counter reaches ACCEL_TICKS: speed += 1 (saturating at SPEED_MAX), counter clears.
  - Speed returns to SPEED_MIN and the counter clears on any of: direction change, STOP, entering IDLE, or a tick where the clamp limits motion (paddle at or reaching a bound).
- Simultaneous key strobe and tick in the same cycle: the tick uses the old direction; the new direction applies from the next tick. Speed reset caused by the key applies in that same cycle.
- CPU mode (i_cpu_mode=1):
  - Key strobes are ignored.
  - On each tick, centre = y + HEIGHT/2. i_ball_y < centre-DEAD_ZONE -> UP; i_ball_y > centre+DEAD_ZONE -> DOWN; otherwise IDLE.
  - Speed is fixed at CPU_SPEED with no ramp.
  - Direction is decided and movement applied in the same tick, from the registered y.
- Mode change (either edge of i_cpu_mode, sampled per clock): next state IDLE, speed=SPEED_MIN, counter cleared; position held.
- o_at_top / o_at_bottom are registered and updated with o_y_pos.
- Legality requirement: START_Y and all outputs stay within [TOP, BOTTOM-HEIGHT]. An illegal START_Y is a parameter error (elaboration assertion).
- No other latency: all outputs are registered, with one-clock latency from tick or strobe.

Decomposition:
- Shared package pong_pkg holds:
  - Direction encoding DIR_IDLE/DIR_UP/DIR_DOWN.
  - Playfield constants TOP/BOTTOM and the screen height 480.
  - Default key codes. Player 2 also consumes these.
- One natural sub-module, paddle_speed_ramp: accel counter plus saturating speed register, with inputs moved/clear/tick.
- The FSM, clamp and CPU compare stay in paddle_ctrl.

Test Plan:
- Reset mid-motion: assert i_RST while o_dir=DOWN and y=320 -> y=300, o_dir=00, o_speed=2 immediately, without a clock edge.
- Ramp: press 's', then 8 ticks -> y 302,304,306,308,311,314,317,320; o_speed=4 after tick 8.
- Bottom clamp: y=360, DOWN, speed 2 -> 362,364,365; o_at_bottom=1 and o_speed=2 after the clamped tick; further ticks hold 365.
- Stop / garbage / simultaneous: 'x' strobe -> no change; space strobe in the same cycle as a tick while UP at y=200 -> y=198 on that tick, o_dir=IDLE, then y stays 198.
- CPU tracking: mode=1, y=300 (centre 350), ball_y=200 -> ticks give y 297,294,...; ball_y=355 with centre 350 -> o_dir=IDLE, y stays put.
- Mode switch: mode 0 DOWN at speed 5 toggles to 1 -> o_dir=IDLE, o_speed resets, y unchanged that cycle.
